// File: rtl/binning_stream_arbiter_if.sv
// Stream bundle between two raster pixel sources, the frame arbiter and the
// downstream binning unit. The arbiter takes the slave view; whatever models
// the sources and the binner takes the master view.
interface binning_stream_arbiter_if #(
  parameter int HRES       = 1280,
  parameter int VRES       = 720,
  parameter int DATA_WIDTH = 1
);
  localparam int HCW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int VCW = (VRES > 1) ? $clog2(VRES) : 1;

  // Source side
  logic [1:0]                 src_valid_in;
  logic [1:0]                 src_sof_in;
  logic [1:0][DATA_WIDTH-1:0] src_data_in;
  logic [1:0]                 src_ready_out;

  // Binner side and status
  logic [DATA_WIDTH-1:0]      pixel_data_out;
  logic [HCW-1:0]             hcount_out;
  logic [VCW-1:0]             vcount_out;
  logic                       data_valid_out;
  logic                       grant_out;
  logic                       busy_out;
  logic                       frame_done_out;
  logic                       sof_err_out;

  modport master (
    output src_valid_in, src_sof_in, src_data_in,
    input  src_ready_out,
    input  pixel_data_out, hcount_out, vcount_out, data_valid_out,
    input  grant_out, busy_out, frame_done_out, sof_err_out
  );

  modport slave (
    input  src_valid_in, src_sof_in, src_data_in,
    output src_ready_out,
    output pixel_data_out, hcount_out, vcount_out, data_valid_out,
    output grant_out, busy_out, frame_done_out, sof_err_out
  );
endinterface

// File: rtl/binning_stream_arbiter.sv
// Frame-granular round-robin arbiter sharing one binning datapath between two
// raster sources. A source owns the datapath for a whole frame; hcount/vcount
// are regenerated here, and idle cycles are inserted after each non-final
// line and after the last pixel so the binner's pipeline can settle.
module binning_stream_arbiter #(
  parameter int HRES         = 1280,
  parameter int VRES         = 720,
  parameter int DATA_WIDTH   = 1,
  parameter int LINE_GAP     = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  binning_stream_arbiter_if.slave bus
);
  localparam int HCW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int VCW = (VRES > 1) ? $clog2(VRES) : 1;
  localparam int GCW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [HCW-1:0] H_LAST     = HCW'(HRES - 1);
  localparam logic [VCW-1:0] V_LAST     = VCW'(VRES - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  // With a zero gap the line-end transfer stays in STREAM.
  localparam bit             HAS_GAP    = (LINE_GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_LINE_GAP,
    ST_DRAIN
  } state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic [HCW-1:0]        col_reg, col_next;
  logic [VCW-1:0]        row_reg, row_next;
  logic [GCW-1:0]        gap_cnt_reg, gap_cnt_next;
  logic [DCW-1:0]        drain_cnt_reg, drain_cnt_next;

  logic [DATA_WIDTH-1:0] pixel_data_reg, pixel_data_next;
  logic [HCW-1:0]        hcount_reg, hcount_next;
  logic [VCW-1:0]        vcount_reg, vcount_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  sof_err_reg, sof_err_next;

  logic [1:0]            req_vec;
  logic [1:0]            ready_vec;
  logic                  xfer;

  // A request is a valid pixel flagged as start-of-frame; anything else in
  // IDLE is left sitting on the source.
  assign req_vec = bus.src_valid_in & bus.src_sof_in;

  // Ready depends only on state and owner so it can never loop back through
  // a source's valid logic.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready_vec[gi] = (state_reg == ST_STREAM) && (grant_reg == 1'(gi));
  end

  assign xfer = (state_reg == ST_STREAM) && bus.src_valid_in[grant_reg];

  // Next-state, counter and output-pixel logic for the frame scheduler.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    col_next        = col_reg;
    row_next        = row_reg;
    gap_cnt_next    = gap_cnt_reg;
    drain_cnt_next  = drain_cnt_reg;
    pixel_data_next = pixel_data_reg;
    hcount_next     = hcount_reg;
    vcount_next     = vcount_reg;
    data_valid_next = 1'b0;
    frame_done_next = 1'b0;
    sof_err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        col_next = '0;
        row_next = '0;
        if (req_vec != 2'b00) begin
          // On a tie the source not served last goes next.
          grant_next = (req_vec == 2'b11) ? ~last_grant_reg : req_vec[1];
          state_next = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (xfer) begin
          pixel_data_next = bus.src_data_in[grant_reg];
          hcount_next     = col_reg;
          vcount_next     = row_reg;
          data_valid_next = 1'b1;
          // A repeated sof is flagged but the pixel is still forwarded.
          sof_err_next    = bus.src_sof_in[grant_reg] &&
                            ((col_reg != '0) || (row_reg != '0));
          if (col_reg == H_LAST) begin
            col_next = '0;
            if (row_reg != V_LAST) begin
              row_next     = row_reg + VCW'(1);
              gap_cnt_next = '0;
              if (HAS_GAP) begin
                state_next = ST_LINE_GAP;
              end
            end else begin
              drain_cnt_next  = '0;
              last_grant_next = grant_reg;
              state_next      = ST_DRAIN;
            end
          end else begin
            col_next = col_reg + HCW'(1);
          end
        end
      end

      ST_LINE_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_STREAM;
        end else begin
          gap_cnt_next = gap_cnt_reg + GCW'(1);
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          frame_done_next = 1'b1;
          state_next      = ST_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg + DCW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      col_reg        <= '0;
      row_reg        <= '0;
      gap_cnt_reg    <= '0;
      drain_cnt_reg  <= '0;
      pixel_data_reg <= '0;
      hcount_reg     <= '0;
      vcount_reg     <= '0;
      data_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      sof_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      gap_cnt_reg    <= gap_cnt_next;
      drain_cnt_reg  <= drain_cnt_next;
      pixel_data_reg <= pixel_data_next;
      hcount_reg     <= hcount_next;
      vcount_reg     <= vcount_next;
      data_valid_reg <= data_valid_next;
      frame_done_reg <= frame_done_next;
      sof_err_reg    <= sof_err_next;
    end
  end

  assign bus.src_ready_out  = ready_vec;
  assign bus.pixel_data_out = pixel_data_reg;
  assign bus.hcount_out     = hcount_reg;
  assign bus.vcount_out     = vcount_reg;
  assign bus.data_valid_out = data_valid_reg;
  assign bus.grant_out      = grant_reg;
  assign bus.busy_out       = (state_reg != ST_IDLE);
  assign bus.frame_done_out = frame_done_reg;
  assign bus.sof_err_out    = sof_err_reg;
endmodule

// File: tb/tb_binning_stream_arbiter.sv
// Bench for binning_stream_arbiter: two scripted raster sources, a scoreboard
// of accepted pixels (expected h/v derived from the pixel's index in its
// frame) checked every cycle, plus hand-computed timing expectations.
`timescale 1ns/1ps
module tb_binning_stream_arbiter;
  localparam int HRES         = 8;
  localparam int VRES         = 4;
  localparam int DATA_WIDTH   = 1;
  localparam int LINE_GAP     = 2;
  localparam int DRAIN_CYCLES = 3;
  localparam int NPIX         = HRES * VRES;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  binning_stream_arbiter_if #(.HRES(HRES), .VRES(VRES), .DATA_WIDTH(DATA_WIDTH)) bus ();

  binning_stream_arbiter #(
    .HRES(HRES), .VRES(VRES), .DATA_WIDTH(DATA_WIDTH),
    .LINE_GAP(LINE_GAP), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  typedef struct {
    int g;
    int h;
    int v;
    int d;
    int e;
  } exp_t;

  exp_t expq[$];
  int   done_grants[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_pulses = 0;
  int   pix_in_frame = 0;
  bit   expect42 = 1'b0;

  // Source scripts
  int frames_left[2] = '{0, 0};
  int idx[2]         = '{0, 0};
  int stall_at[2]    = '{-1, -1};
  int stall_cnt[2]   = '{0, 0};
  int err_at[2]      = '{-1, -1};
  bit nosof[2]       = '{1'b0, 1'b0};
  int req_cyc[2]     = '{0, 0};
  int xfer_cyc[2][NPIX];

  function automatic void chk_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int pix_data(input int s, input int k);
    return ((k * 5 + s * 3) >> 1) & 1;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Source drivers: present pixels on the falling edge and log each accepted
  // pixel with the raster position it must come out with.
  initial begin
    bit v, f;
    int pd;
    bus.src_valid_in = '0;
    bus.src_sof_in   = '0;
    bus.src_data_in  = '0;
    forever begin
      @(negedge clk_in);
      for (int s = 0; s < 2; s++) begin
        v = 1'b0;
        f = 1'b0;
        if (frames_left[s] > 0 && stall_cnt[s] == 0) begin
          v = 1'b1;
          f = (idx[s] == 0 && !nosof[s]) || (idx[s] == err_at[s]);
        end else if (stall_cnt[s] > 0) begin
          stall_cnt[s]--;
        end
        pd = pix_data(s, idx[s]);
        bus.src_valid_in[s] = v;
        bus.src_sof_in[s]   = f;
        bus.src_data_in[s]  = DATA_WIDTH'(pd);
        if (v && f && idx[s] == 0 && !bus.busy_out) req_cyc[s] = cyc;
        if (v && bus.src_ready_out[s]) begin
          expq.push_back('{s, idx[s] % HRES, idx[s] / HRES, pd,
                           (f && idx[s] != 0) ? 1 : 0});
          xfer_cyc[s][idx[s]] = cyc;
          idx[s]++;
          if (idx[s] == NPIX) begin
            idx[s] = 0;
            frames_left[s]--;
          end
          if (idx[s] == stall_at[s]) stall_cnt[s] = 5;
        end
      end
    end
  end

  // Output compare, every cycle out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #2;
      if (rst_in) begin
        checks++;
        if (bus.src_ready_out == 2'b11) begin
          errors++;
          $display("FAIL ready_exclusive: got %b, required not 11", bus.src_ready_out);
        end
        if (!bus.busy_out)
          chk_eq("ready_idle", int'(bus.src_ready_out), 0);
        else if (bus.src_ready_out != 2'b00)
          chk_eq("ready_owner", int'(bus.src_ready_out), 1 << bus.grant_out);
        if (bus.data_valid_out) begin
          if (expq.size() == 0) begin
            chk_eq("unexpected_pixel_q", 0, 1);
          end else begin
            e = expq.pop_front();
            chk_eq("hcount", int'(bus.hcount_out), e.h);
            chk_eq("vcount", int'(bus.vcount_out), e.v);
            chk_eq("pixel_data", int'(bus.pixel_data_out), e.d);
            chk_eq("grant", int'(bus.grant_out), e.g);
            chk_eq("sof_err", int'(bus.sof_err_out), e.e);
          end
          pix_in_frame++;
        end else begin
          chk_eq("sof_err_idle", int'(bus.sof_err_out), 0);
        end
        if (bus.sof_err_out) err_pulses++;
        if (bus.frame_done_out) begin
          done_cnt++;
          done_grants.push_back(int'(bus.grant_out));
          chk_eq("frame_pixels", pix_in_frame, NPIX);
          pix_in_frame = 0;
          if (expect42) chk_eq("frame_cycles", cyc - req_cyc[bus.grant_out], 42);
        end
      end else begin
        pix_in_frame = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #3;
  endtask

  task automatic reset_all();
    rst_in = 1'b0;
    for (int s = 0; s < 2; s++) begin
      frames_left[s] = 0;
      idx[s]         = 0;
      stall_at[s]    = -1;
      stall_cnt[s]   = 0;
      err_at[s]      = -1;
      nosof[s]       = 1'b0;
    end
    expq.delete();
    done_grants.delete();
    done_cnt   = 0;
    err_pulses = 0;
    expect42   = 1'b0;
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk_eq("frame_done_reached", done_cnt, target);
    chk_eq("queue_drained", expq.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_ready"}, int'(bus.src_ready_out), 0);
    chk_eq({tag, "_data_valid"}, int'(bus.data_valid_out), 0);
    chk_eq({tag, "_pixel"}, int'(bus.pixel_data_out), 0);
    chk_eq({tag, "_hcount"}, int'(bus.hcount_out), 0);
    chk_eq({tag, "_vcount"}, int'(bus.vcount_out), 0);
    chk_eq({tag, "_grant"}, int'(bus.grant_out), 0);
    chk_eq({tag, "_busy"}, int'(bus.busy_out), 0);
    chk_eq({tag, "_frame_done"}, int'(bus.frame_done_out), 0);
    chk_eq({tag, "_sof_err"}, int'(bus.sof_err_out), 0);
  endtask

  initial begin
    int n, base;
    bit found;

    rst_in = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_in = 1'b1;
    tick();

    // 1: single source 0, always valid
    expect42 = 1'b1;
    frames_left[0] = 1;
    wait_done(1, 200);
    if (done_grants.size() > 0) chk_eq("s1_grant", done_grants[0], 0);
    chk_eq("s1_first_xfer_latency", xfer_cyc[0][0] - req_cyc[0], 1);
    chk_eq("s1_in_line_step", xfer_cyc[0][1] - xfer_cyc[0][0], 1);
    chk_eq("s1_gap_row0", xfer_cyc[0][8] - xfer_cyc[0][7], 3);
    chk_eq("s1_gap_row1", xfer_cyc[0][16] - xfer_cyc[0][15], 3);
    chk_eq("s1_gap_row2", xfer_cyc[0][24] - xfer_cyc[0][23], 3);
    $display("scenario single_source: frames=%0d", done_cnt);

    // 2: both sources requesting continuously
    reset_all();
    expect42 = 1'b1;
    frames_left[0] = 2;
    frames_left[1] = 2;
    wait_done(4, 400);
    for (int i = 0; i < 4; i++)
      if (i < done_grants.size()) chk_eq("s2_grant_order", done_grants[i], i % 2);
    $display("scenario round_robin: frames=%0d", done_cnt);

    // 3: source 0 stalls 5 cycles after pixel (3,1)
    reset_all();
    stall_at[0] = 12;
    frames_left[0] = 1;
    wait_done(1, 200);
    chk_eq("s3_stall_span", xfer_cyc[0][12] - xfer_cyc[0][11], 6);
    chk_eq("s3_resume_step", xfer_cyc[0][13] - xfer_cyc[0][12], 1);
    $display("scenario stall: frames=%0d", done_cnt);

    // 4: repeated sof at pixel (5,2)
    reset_all();
    err_at[0] = 21;
    frames_left[0] = 1;
    wait_done(1, 200);
    chk_eq("s4_sof_err_pulses", err_pulses, 1);
    $display("scenario sof_error: pulses=%0d", err_pulses);

    // 5: reset in the row-2 gap, after one completed source-0 frame
    reset_all();
    frames_left[0] = 1;
    wait_done(1, 200);
    frames_left[0] = 1;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (bus.data_valid_out && bus.hcount_out == 3'd7 && bus.vcount_out == 2'd2)
        found = 1'b1;
    end
    chk_eq("s5_reached_row2_end", int'(found), 1);
    rst_in = 1'b0;
    #1;
    check_all_zero("midreset");
    frames_left[0] = 0;
    idx[0] = 0;
    expq.delete();
    tick();
    rst_in = 1'b1;
    base = done_cnt;
    repeat (20) tick();
    chk_eq("s5_no_frame_done", done_cnt, base);
    frames_left[0] = 1;
    frames_left[1] = 1;
    wait_done(base + 2, 300);
    if (done_grants.size() >= base + 2) begin
      chk_eq("s5_tie_after_reset_first", done_grants[base], 0);
      chk_eq("s5_tie_after_reset_second", done_grants[base + 1], 1);
    end
    $display("scenario midframe_reset: frames=%0d", done_cnt);

    // 6: source 1 valid without sof in IDLE, then sof
    reset_all();
    nosof[1] = 1'b1;
    frames_left[1] = 1;
    repeat (5) begin
      tick();
      chk_eq("s6_ready_no_sof", int'(bus.src_ready_out), 0);
      chk_eq("s6_busy_no_sof", int'(bus.busy_out), 0);
      chk_eq("s6_not_consumed", idx[1], 0);
    end
    nosof[1] = 1'b0;
    tick();
    chk_eq("s6_ready_after_sof", int'(bus.src_ready_out), 2);
    chk_eq("s6_grant_after_sof", int'(bus.grant_out), 1);
    wait_done(1, 200);
    if (done_grants.size() > 0) chk_eq("s6_frame_grant", done_grants[0], 1);
    $display("scenario no_sof_then_sof: frames=%0d", done_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
